filter_fetch_ctrl: RTL and testbench

- Read-side controller for the filter weight ROM, which has a registered 1-cycle read: address in, filter_out valid one edge later.
- Generates ROM addresses and gathers nine consecutive bytes into one 3x3 kernel word.
- Presents each kernel to the convolution engine over a valid/ready handshake.
- Fetches a contiguous run of kernels per start command; the ROM holds 216 bytes = 24 kernels.

---
 rtl/filter_fetch_ctrl_if.sv | 22 ++
 rtl/filter_fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_filter_fetch_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_fetch_ctrl_if.sv
// Kernel stream between the fetch controller and the convolution engine.
//
// Handshake: the master raises kernel_valid with a complete kernel on
// kernel_out and holds both stable until it samples kernel_ready=1 on a
// rising clock edge; that edge is the transfer. kernel_ready is a don't-care
// while kernel_valid=0.
//
// Signals:
//   kernel_out    master->slave  KSIZE*DATA_W  packed kernel, element i in bits [DATA_W*i +: DATA_W]
//   kernel_valid  master->slave  1             kernel_out holds a complete kernel
//   kernel_ready  slave->master  1             consumer accepts the kernel
interface filter_fetch_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int KSIZE  = 9
);
    logic [KSIZE*DATA_W-1:0] kernel_out;
    logic                    kernel_valid;
    logic                    kernel_ready;

    modport master (output kernel_out, output kernel_valid, input kernel_ready);
    modport slave  (input kernel_out, input kernel_valid, output kernel_ready);
endinterface

// File: rtl/filter_fetch_ctrl.sv
// Read-side controller for the filter weight ROM (registered 1-cycle read).
// On a start command it fetches a contiguous run of 3x3 kernels: nine byte
// addresses per kernel, bytes gathered into one packed kernel word, each kernel
// presented on the kernel stream and held until accepted. No prefetch.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-low reset
//   start         in   command pulse, only looked at while idle
//   first_kernel  in   index of the first kernel of the run
//   num_kernels   in   number of kernels in the run (0 = empty run)
//   filter_addr   out  registered ROM byte address
//   filter_data   in   ROM data, valid one edge after filter_addr
//   kern          master side of the kernel stream (kernel_out/valid/ready)
//   busy          out  high whenever the controller is not idle
//   done          out  one-cycle pulse when a command completes
//   cmd_err       out  one-cycle pulse when a command is rejected (out of range)
//   dbg_state     out  current FSM state
module filter_fetch_ctrl #(
    parameter int DATA_W = 8,
    parameter int KSIZE  = 9,
    parameter int NUM_K  = 24,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4:0]           first_kernel,
    input  logic [4:0]           num_kernels,
    output logic [ADDR_W-1:0]    filter_addr,
    input  logic [DATA_W-1:0]    filter_data,
    filter_fetch_ctrl_if.master  kern,
    output logic                 busy,
    output logic                 done,
    output logic                 cmd_err,
    output logic [2:0]           dbg_state
);
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HOLD, FINISH} state_t;

    state_t                  state, state_n;
    logic [4:0]              cur_k, cur_k_n;
    logic [4:0]              remaining, remaining_n;
    // elem counts addresses already issued for the current kernel.
    logic [3:0]              elem, elem_n;
    logic [ADDR_W-1:0]       addr_q, addr_n;
    logic                    valid_q, valid_n;
    logic                    done_n, err_n;
    logic [KSIZE*DATA_W-1:0] kernel_q;

    // An issued address returns data two edges later; this two-stage
    // pipeline carries the destination slot alongside.
    logic                    issue;
    logic [3:0]              issue_slot;
    logic                    p1_v, p2_v;
    logic [3:0]              p1_slot, p2_slot;

    function automatic logic [ADDR_W-1:0] kbase(input logic [4:0] k);
        return ADDR_W'(k) * ADDR_W'(KSIZE);
    endfunction

    always_comb begin
        state_n     = state;
        cur_k_n     = cur_k;
        remaining_n = remaining;
        elem_n      = elem;
        addr_n      = addr_q;
        valid_n     = valid_q;
        done_n      = 1'b0;
        err_n       = 1'b0;
        issue       = 1'b0;
        issue_slot  = 4'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_kernels == 5'd0) begin
                        state_n = FINISH;
                    end else if (({1'b0, first_kernel} + {1'b0, num_kernels}) > 6'(NUM_K)) begin
                        err_n = 1'b1;
                    end else begin
                        cur_k_n     = first_kernel;
                        remaining_n = num_kernels;
                        addr_n      = kbase(first_kernel);
                        issue       = 1'b1;
                        elem_n      = 4'd1;
                        state_n     = FETCH;
                    end
                end
            end
            FETCH: begin
                if (elem == 4'(KSIZE)) begin
                    state_n = DRAIN;
                end else begin
                    addr_n     = kbase(cur_k) + ADDR_W'(elem);
                    issue      = 1'b1;
                    issue_slot = elem;
                    elem_n     = elem + 4'd1;
                end
            end
            DRAIN: begin
                // The last byte lands in its slot on this edge.
                valid_n = 1'b1;
                state_n = HOLD;
            end
            HOLD: begin
                if (kern.kernel_ready) begin
                    valid_n     = 1'b0;
                    remaining_n = remaining - 5'd1;
                    if (remaining == 5'd1) begin
                        state_n = FINISH;
                    end else begin
                        // Issue the next kernel's first address on the
                        // handshake edge so kernels complete every 11 cycles.
                        cur_k_n = cur_k + 5'd1;
                        addr_n  = kbase(cur_k + 5'd1);
                        issue   = 1'b1;
                        elem_n  = 4'd1;
                        state_n = FETCH;
                    end
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur_k     <= '0;
            remaining <= '0;
            elem      <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            kernel_q  <= '0;
            p1_v      <= 1'b0;
            p2_v      <= 1'b0;
            p1_slot   <= '0;
            p2_slot   <= '0;
        end else begin
            state     <= state_n;
            cur_k     <= cur_k_n;
            remaining <= remaining_n;
            elem      <= elem_n;
            addr_q    <= addr_n;
            valid_q   <= valid_n;
            done      <= done_n;
            cmd_err   <= err_n;
            p1_v      <= issue;
            p1_slot   <= issue_slot;
            p2_v      <= p1_v;
            p2_slot   <= p1_slot;
            if (p2_v) begin
                kernel_q[p2_slot*DATA_W +: DATA_W] <= filter_data;
            end
        end
    end

    assign filter_addr       = addr_q;
    assign kern.kernel_out   = kernel_q;
    assign kern.kernel_valid = valid_q;
    assign busy              = (state != IDLE);
    assign dbg_state         = state;
endmodule

// File: tb/tb_filter_fetch_ctrl.sv
// Bench for filter_fetch_ctrl: a registered ROM model, a timeline-based
// reference model of the command/kernel protocol, a per-cycle compare
// process, directed scenarios with literal expectations and a random phase.
module tb_filter_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  first_kernel = '0;
    logic [4:0]  num_kernels = '0;
    logic [7:0]  filter_addr;
    logic [7:0]  filter_data = '0;
    logic        busy, done, cmd_err;
    logic [2:0]  dbg_state;
    logic [7:0]  rom [256];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    filter_fetch_ctrl_if kif ();

    filter_fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .first_kernel (first_kernel),
        .num_kernels  (num_kernels),
        .filter_addr  (filter_addr),
        .filter_data  (filter_data),
        .kern         (kif),
        .busy         (busy),
        .done         (done),
        .cmd_err      (cmd_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / ROM ----------------
    always #5 clk = ~clk;

    always @(posedge clk) filter_data <= rom[filter_addr];

    // ---------------- reference model ----------------
    // A kernel fetch begun at edge s puts address base+d out at edge s+d
    // (d=0..8) and raises valid at edge s+10. A command ends with done one
    // edge after its last handshake (or after start for an empty run).
    int          cyc = 0;
    bit          m_busy, m_fetch, m_valid, m_done, m_err;
    int          m_k, m_left, m_s, m_fin_at;
    logic [7:0]  m_addr;
    logic [71:0] m_kout;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_fetch = 0; m_valid = 0; m_done = 0; m_err = 0;
            m_addr = '0; m_kout = '0; m_fin_at = -1; m_k = 0; m_left = 0; m_s = 0;
        end else begin
            int d;
            cyc++;
            m_done = 0;
            m_err  = 0;
            if (m_fin_at == cyc) begin
                m_done = 1; m_busy = 0; m_fin_at = -1;
            end else if (!m_busy) begin
                if (start) begin
                    if (num_kernels == 0) begin
                        m_busy = 1; m_fin_at = cyc + 1;
                    end else if (int'(first_kernel) + int'(num_kernels) > 24) begin
                        m_err = 1;
                    end else begin
                        m_busy = 1; m_k = first_kernel; m_left = num_kernels;
                        m_fetch = 1; m_s = cyc;
                    end
                end
            end else if (m_valid && kif.kernel_ready) begin
                m_valid = 0;
                m_left--;
                if (m_left == 0) m_fin_at = cyc + 1;
                else begin m_k++; m_fetch = 1; m_s = cyc; end
            end
            if (m_fetch) begin
                d = cyc - m_s;
                if (d <= 8) m_addr = 8'(m_k * 9 + d);
                if (d == 10) begin
                    m_valid = 1; m_fetch = 0;
                    for (int i = 0; i < 9; i++) m_kout[i*8 +: 8] = rom[m_k*9 + i];
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("cmd_err", cmd_err, m_err);
            check("filter_addr", filter_addr, m_addr);
            check("kernel_valid", kif.kernel_valid, m_valid);
            if (m_valid) check("kernel_out", kif.kernel_out, m_kout);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int f, input int n);
        start = 1'b1;
        first_kernel = 5'(f);
        num_kernels = 5'(n);
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!kif.kernel_valid && k < 300) begin step(); k++; end
        check(name, kif.kernel_valid, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 2000) begin step(); k++; end
        check(name, busy, 1'b0);
        step();
    endtask

    function automatic logic [71:0] kern_of(input int k);
        logic [71:0] v;
        for (int i = 0; i < 9; i++) v[i*8 +: 8] = rom[k*9 + i];
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [71:0] exp_k;
        for (int a = 0; a < 256; a++) rom[a] = 8'(a);
        kif.kernel_ready = 1'b1;
        #1 reset = 1'b0;
        step(); step();
        check("rst_busy", busy, 1'b0);
        check("rst_addr", filter_addr, 8'd0);
        check("rst_valid", kif.kernel_valid, 1'b0);
        check("rst_kout", kif.kernel_out, 72'd0);
        check("rst_done_err", {done, cmd_err}, 2'b00);
        #2 reset = 1'b1;
        chk_en = 1'b1;
        step();

        // Single kernel 0, literal timeline.
        pulse_start(0, 1);
        check("t1_addr0", filter_addr, 8'd0);
        for (int j = 1; j <= 12; j++) begin
            step();
            if (j <= 8) check("t1_addr", filter_addr, 8'(j));
            if (j == 9) check("t1_valid_early", kif.kernel_valid, 1'b0);
            if (j == 10) begin
                check("t1_valid", kif.kernel_valid, 1'b1);
                check("t1_kout", kif.kernel_out, 72'h080706050403020100);
            end
            if (j == 11) check("t1_done_early", done, 1'b0);
            if (j == 12) check("t1_done", done, 1'b1);
        end
        step();

        // Last kernel in ROM.
        pulse_start(23, 1);
        check("t2_addr_first", filter_addr, 8'd207);
        wait_valid("t2_valid_timeout");
        for (int i = 0; i < 9; i++) exp_k[i*8 +: 8] = 8'(207 + i);
        check("t2_kout", kif.kernel_out, exp_k);
        check("t2_addr_last", filter_addr, 8'd215);
        wait_idle("t2_idle_timeout");

        // Out-of-range command.
        pulse_start(20, 5);
        check("t3_err", cmd_err, 1'b1);
        check("t3_busy", busy, 1'b0);
        check("t3_addr", filter_addr, 8'd215);
        step();
        check("t3_err_pulse", cmd_err, 1'b0);

        // Backpressure with random ROM contents.
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom_range(0, 255));
        step();
        kif.kernel_ready = 1'b0;
        pulse_start(0, 2);
        wait_valid("t4_valid_timeout");
        for (int j = 0; j < 7; j++) begin
            step();
            check("t4_hold_valid", kif.kernel_valid, 1'b1);
            check("t4_hold_kout", kif.kernel_out, kern_of(0));
            check("t4_hold_addr", filter_addr, 8'd8);
        end
        kif.kernel_ready = 1'b1;
        step();
        check("t4_next_addr", filter_addr, 8'd9);
        check("t4_valid_drop", kif.kernel_valid, 1'b0);
        wait_valid("t4_valid2_timeout");
        check("t4_kout2", kif.kernel_out, kern_of(1));
        step();
        check("t4_done_early", done, 1'b0);
        step();
        check("t4_done", done, 1'b1);
        step();

        // Empty run, then ignored start during FETCH.
        pulse_start(7, 0);
        check("t5_busy", busy, 1'b1);
        check("t5_addr_hold", filter_addr, 8'd17);
        step();
        check("t5_done", done, 1'b1);
        step();
        pulse_start(2, 1);
        step(); step();
        pulse_start(10, 3);
        check("t5_ignored_addr", filter_addr, 8'd21);
        wait_valid("t5_valid_timeout");
        check("t5_kout", kif.kernel_out, kern_of(2));
        wait_idle("t5_idle_timeout");

        // Asynchronous reset in the middle of a fetch.
        pulse_start(5, 2);
        for (int j = 0; j < 4; j++) step();
        check("t6_addr_mid", filter_addr, 8'd49);
        #2 reset = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_addr", filter_addr, 8'd0);
        check("t6_valid_done", {kif.kernel_valid, done, cmd_err}, 3'b000);
        check("t6_kout", kif.kernel_out, 72'd0);
        step(); step();
        reset = 1'b1;
        step();
        pulse_start(1, 1);
        wait_valid("t6_valid_timeout");
        check("t6_kout_after", kif.kernel_out, kern_of(1));
        wait_idle("t6_idle_timeout");

        // Random commands and backpressure.
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 15) == 0);
            first_kernel = 5'($urandom_range(0, 23));
            num_kernels = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 24))
                                                       : 5'($urandom_range(0, 3));
            kif.kernel_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        start = 1'b0;
        kif.kernel_ready = 1'b1;
        wait_idle("rand_idle_timeout");
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
